// File: rtl/cheri_check_arbiter.sv
// cheri_check_arbiter
//   Shares one CHERI capability-check datapath between instruction fetch
//   (id 0, execute access) and data load/store (id 1). Requests are
//   round-robin arbitrated in IDLE. The winner is captured in a holding
//   register and checked in CHECK, in the order tag, then bounds, then
//   permission. The result is presented in RESP until the consumer accepts it.
//   The first fault is latched in a sticky register for the trap unit.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   f_req_valid/f_req_ready           fetch request handshake (ready is combinational)
//   f_tag/f_base/f_length/f_addr      fetch capability and address
//   f_perm_exec                       capability grants execute
//   d_req_valid/d_req_ready           data request handshake (ready is combinational)
//   d_tag/d_base/d_length/d_addr      data capability and address
//   d_is_store, d_perm_load/store     access kind and granted permissions
//   resp_valid/resp_ready             registered result channel
//   resp_id/resp_ok/resp_cause        requester, pass flag, cause (0 none,1 tag,2 bounds,3 perm)
//   fault_valid/id/cause/addr         sticky first-fault record
//   fault_clr                         clears the sticky fault record
module cheri_check_arbiter #(
    parameter int ADDR_W       = 128,
    parameter int ACCESS_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic              f_tag,
    input  logic [ADDR_W-1:0] f_base,
    input  logic [ADDR_W-1:0] f_length,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_perm_exec,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_tag,
    input  logic [ADDR_W-1:0] d_base,
    input  logic [ADDR_W-1:0] d_length,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_is_store,
    input  logic              d_perm_load,
    input  logic              d_perm_store,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic              resp_ok,
    output logic [2:0]        resp_cause,
    output logic              fault_valid,
    output logic              fault_id,
    output logic [2:0]        fault_cause,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clr
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_TAG    = 3'd1;
    localparam logic [2:0] CAUSE_BOUNDS = 3'd2;
    localparam logic [2:0] CAUSE_PERM   = 3'd3;
    localparam logic [ADDR_W:0] LAST_OFS = (ADDR_W+1)'(ACCESS_BYTES - 1);

    state_t            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              h_id_q, h_id_d;
    logic              h_tag_q, h_tag_d;
    logic              h_perm_ok_q, h_perm_ok_d;
    logic [ADDR_W-1:0] h_base_q, h_base_d;
    logic [ADDR_W-1:0] h_len_q, h_len_d;
    logic [ADDR_W-1:0] h_addr_q, h_addr_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic              resp_ok_q, resp_ok_d;
    logic [2:0]        resp_cause_q, resp_cause_d;
    logic              fault_valid_q, fault_valid_d;
    logic              fault_id_q, fault_id_d;
    logic [2:0]        fault_cause_q, fault_cause_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    logic              grant_f, grant_d;
    logic [ADDR_W:0]   cap_top, acc_last;
    logic              bounds_fail;
    logic [2:0]        chk_cause;

    // On a tie the requester that did not win last time gets the grant.
    assign grant_f = f_req_valid && (!d_req_valid || rr_last_q);
    assign grant_d = d_req_valid && (!f_req_valid || !rr_last_q);

    // One extra bit so base+length and addr+size-1 cannot wrap.
    assign cap_top     = {1'b0, h_base_q} + {1'b0, h_len_q};
    assign acc_last    = {1'b0, h_addr_q} + LAST_OFS;
    assign bounds_fail = (h_addr_q < h_base_q) || (acc_last >= cap_top);

    always_comb begin
        chk_cause = CAUSE_NONE;
        if (!h_tag_q)
            chk_cause = CAUSE_TAG;
        else if (bounds_fail)
            chk_cause = CAUSE_BOUNDS;
        else if (!h_perm_ok_q)
            chk_cause = CAUSE_PERM;
    end

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        h_id_d        = h_id_q;
        h_tag_d       = h_tag_q;
        h_perm_ok_d   = h_perm_ok_q;
        h_base_d      = h_base_q;
        h_len_d       = h_len_q;
        h_addr_d      = h_addr_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_ok_d     = resp_ok_q;
        resp_cause_d  = resp_cause_q;
        fault_valid_d = fault_valid_q;
        fault_id_d    = fault_id_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;
        f_req_ready   = 1'b0;
        d_req_ready   = 1'b0;

        // A fault latched in CHECK below takes precedence over this clear.
        if (fault_clr)
            fault_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                f_req_ready = grant_f;
                d_req_ready = grant_d;
                if (grant_f) begin
                    h_id_d      = 1'b0;
                    h_tag_d     = f_tag;
                    h_base_d    = f_base;
                    h_len_d     = f_length;
                    h_addr_d    = f_addr;
                    h_perm_ok_d = f_perm_exec;
                    rr_last_d   = 1'b0;
                    state_d     = S_CHECK;
                end else if (grant_d) begin
                    h_id_d      = 1'b1;
                    h_tag_d     = d_tag;
                    h_base_d    = d_base;
                    h_len_d     = d_length;
                    h_addr_d    = d_addr;
                    // Only the permission relevant to this access kind matters.
                    h_perm_ok_d = d_is_store ? d_perm_store : d_perm_load;
                    rr_last_d   = 1'b1;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                resp_valid_d = 1'b1;
                resp_id_d    = h_id_q;
                resp_ok_d    = (chk_cause == CAUSE_NONE);
                resp_cause_d = chk_cause;
                if ((chk_cause != CAUSE_NONE) && (!fault_valid_q || fault_clr)) begin
                    fault_valid_d = 1'b1;
                    fault_id_d    = h_id_q;
                    fault_cause_d = chk_cause;
                    fault_addr_d  = h_addr_q;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_last_q     <= 1'b1;
            h_id_q        <= 1'b0;
            h_tag_q       <= 1'b0;
            h_perm_ok_q   <= 1'b0;
            h_base_q      <= '0;
            h_len_q       <= '0;
            h_addr_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_ok_q     <= 1'b0;
            resp_cause_q  <= CAUSE_NONE;
            fault_valid_q <= 1'b0;
            fault_id_q    <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            h_id_q        <= h_id_d;
            h_tag_q       <= h_tag_d;
            h_perm_ok_q   <= h_perm_ok_d;
            h_base_q      <= h_base_d;
            h_len_q       <= h_len_d;
            h_addr_q      <= h_addr_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_ok_q     <= resp_ok_d;
            resp_cause_q  <= resp_cause_d;
            fault_valid_q <= fault_valid_d;
            fault_id_q    <= fault_id_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_ok     = resp_ok_q;
    assign resp_cause  = resp_cause_q;
    assign fault_valid = fault_valid_q;
    assign fault_id    = fault_id_q;
    assign fault_cause = fault_cause_q;
    assign fault_addr  = fault_addr_q;

endmodule
